// File: rtl/elastic_pipe_stage.sv
// Elastic inter-stage pipeline register with valid/ready flow control, flush and an
// optional two-entry skid buffer that keeps in_ready off the out_ready timing path.
module elastic_pipe_stage #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 2,
    parameter int SKID    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         count
);

    localparam int PL_W = DATA_W + INSTR_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    logic [PL_W-1:0] w_in_pl;
    logic [PL_W-1:0] w_head_pl;
    logic            w_out_valid;

    assign w_in_pl = {in_ctrl, in_instr, in_data};

    generate
        if (SKID != 0) begin : g_skid
            state_t          r_state;
            state_t          w_state_nxt;
            logic            r_in_ready;
            logic [PL_W-1:0] r_head_pl;
            logic [PL_W-1:0] r_skid_pl;
            logic            w_accept;
            logic            w_send;
            logic            w_load_head;
            logic            w_load_skid;
            logic            w_head_from_skid;

            assign w_accept = in_valid & r_in_ready;
            assign w_send   = (r_state != EMPTY) & out_ready;

            always_comb begin
                w_state_nxt      = r_state;
                w_load_head      = 1'b0;
                w_load_skid      = 1'b0;
                w_head_from_skid = 1'b0;
                case (r_state)
                    EMPTY: begin
                        if (w_accept) begin
                            w_state_nxt = ONE;
                            w_load_head = 1'b1;
                        end
                    end
                    ONE: begin
                        if (w_accept && w_send) begin
                            w_load_head = 1'b1;
                        end else if (w_accept) begin
                            w_state_nxt = TWO;
                            w_load_skid = 1'b1;
                        end else if (w_send) begin
                            w_state_nxt = EMPTY;
                        end
                    end
                    TWO: begin
                        // in_ready is low here, so the only possible move is a drain
                        if (w_send) begin
                            w_state_nxt      = ONE;
                            w_head_from_skid = 1'b1;
                        end
                    end
                    default: w_state_nxt = EMPTY;
                endcase
                if (flush) begin
                    w_state_nxt      = EMPTY;
                    w_load_head      = 1'b0;
                    w_load_skid      = 1'b0;
                    w_head_from_skid = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state    <= EMPTY;
                    r_in_ready <= 1'b1;
                    r_head_pl  <= '0;
                    r_skid_pl  <= '0;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != TWO);
                    if (w_load_head) begin
                        r_head_pl <= w_in_pl;
                    end else if (w_head_from_skid) begin
                        r_head_pl <= r_skid_pl;
                    end
                    if (w_load_skid) begin
                        r_skid_pl <= w_in_pl;
                    end
                end
            end

            assign in_ready    = r_in_ready;
            assign w_out_valid = (r_state != EMPTY);
            assign w_head_pl   = r_head_pl;
            assign count       = r_state;
        end else begin : g_single
            logic            r_valid;
            logic [PL_W-1:0] r_head_pl;
            logic            w_in_ready;
            logic            w_accept;
            logic            w_send;

            assign w_in_ready = out_ready | ~r_valid;
            assign w_accept   = in_valid & w_in_ready;
            assign w_send     = r_valid & out_ready;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid   <= 1'b0;
                    r_head_pl <= '0;
                end else if (flush) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid   <= 1'b1;
                    r_head_pl <= w_in_pl;
                end else if (w_send) begin
                    r_valid <= 1'b0;
                end
            end

            assign in_ready    = w_in_ready;
            assign w_out_valid = r_valid;
            assign w_head_pl   = r_head_pl;
            assign count       = {1'b0, r_valid};
        end
    endgenerate

    // Control bits are masked on bubbles so a stale head can never fire a write-back
    assign out_valid = w_out_valid;
    assign out_data  = w_head_pl[DATA_W-1:0];
    assign out_instr = w_head_pl[DATA_W +: INSTR_W];
    assign out_ctrl  = w_out_valid ? w_head_pl[PL_W-1 -: CTRL_W] : '0;

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Bench for elastic_pipe_stage: directed scenarios on SKID=1 and SKID=0 instances,
// then a random valid/ready/flush run against a FIFO scoreboard.
module tb_elastic_pipe_stage;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [31:0] instr;
        logic [63:0] data;
    } pl_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [31:0] a_in_instr, a_out_instr;
    logic [1:0]  a_in_ctrl, a_out_ctrl, a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [31:0] b_in_instr, b_out_instr;
    logic [1:0]  b_in_ctrl, b_out_ctrl, b_count;

    int n_vec = 0;
    int n_err = 0;

    pl_t qa[$];
    pl_t qb[$];

    always #5 clk = ~clk;

    elastic_pipe_stage #(.DATA_W(64), .INSTR_W(32), .CTRL_W(2), .SKID(1)) u_skid (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_instr(a_in_instr), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_instr(a_out_instr), .out_ctrl(a_out_ctrl),
        .count(a_count)
    );

    elastic_pipe_stage #(.DATA_W(64), .INSTR_W(32), .CTRL_W(2), .SKID(0)) u_single (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_instr(b_in_instr), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_instr(b_out_instr), .out_ctrl(b_out_ctrl),
        .count(b_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid got %b exp 0", a_out_valid); end
        n_vec++; if (a_out_ctrl !== 2'b00) begin n_err++; $display("FAIL rst_a_ctrl got %b exp 00", a_out_ctrl); end
        n_vec++; if (a_count !== 2'd0) begin n_err++; $display("FAIL rst_a_count got %0d exp 0", a_count); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_a_in_ready got %b exp 1", a_in_ready); end
        n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_valid got %b exp 0", b_out_valid); end
        n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_b_in_ready got %b exp 1", b_in_ready); end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1;
        a_in_ctrl   = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 64'(i);
            a_in_instr = 32'(i + 100);
            step();
            n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d got %b exp 1", i, a_out_valid); end
            n_vec++; if (a_out_data !== 64'(i)) begin n_err++; $display("FAIL b2b_data%0d got %0d exp %0d", i, a_out_data, i); end
            n_vec++; if (a_count !== 2'd1) begin n_err++; $display("FAIL b2b_count%0d got %0d exp 1", i, a_count); end
        end
        a_in_valid = 1'b0;
        step();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain_valid got %b exp 0", a_out_valid); end
        n_vec++; if (a_count !== 2'd0) begin n_err++; $display("FAIL b2b_drain_count got %0d exp 0", a_count); end
    endtask

    task automatic test_skid();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'hAA;
        step();
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_rdy_one got %b exp 1", a_in_ready); end
        a_in_data = 64'hBB;
        step();
        a_in_valid = 1'b0;
        a_in_data  = 64'hCC;
        n_vec++; if (a_count !== 2'd2) begin n_err++; $display("FAIL skid_count_two got %0d exp 2", a_count); end
        n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_rdy_two got %b exp 0", a_in_ready); end
        n_vec++; if (a_out_data !== 64'hAA) begin n_err++; $display("FAIL skid_head got %h exp aa", a_out_data); end
        step();
        n_vec++; if (a_out_data !== 64'hAA) begin n_err++; $display("FAIL skid_stall got %h exp aa", a_out_data); end
        n_vec++; if (a_count !== 2'd2) begin n_err++; $display("FAIL skid_stall_count got %0d exp 2", a_count); end
        a_out_ready = 1'b1;
        step();
        n_vec++; if (a_out_data !== 64'hBB) begin n_err++; $display("FAIL skid_second got %h exp bb", a_out_data); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_rdy_after got %b exp 1", a_in_ready); end
        n_vec++; if (a_count !== 2'd1) begin n_err++; $display("FAIL skid_count_after got %0d exp 1", a_count); end
        step();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL skid_empty got %b exp 0", a_out_valid); end
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0;
        a_in_ctrl   = 2'b11;
        a_in_valid  = 1'b1;
        a_in_data   = 64'hAA;
        step();
        a_in_data = 64'hBB;
        step();
        a_in_data = 64'hDD;
        a_flush   = 1'b1;
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush2_valid got %b exp 0", a_out_valid); end
        n_vec++; if (a_count !== 2'd0) begin n_err++; $display("FAIL flush2_count got %0d exp 0", a_count); end
        n_vec++; if (a_out_ctrl !== 2'b00) begin n_err++; $display("FAIL flush2_ctrl got %b exp 00", a_out_ctrl); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush2_rdy got %b exp 1", a_in_ready); end
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost%0d got %b exp 0", i, a_out_valid); end
        end
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'hEE;
        step();
        a_in_data = 64'hFF;
        a_flush   = 1'b1;
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        n_vec++; if (a_count !== 2'd0) begin n_err++; $display("FAIL flush1_count got %0d exp 0", a_count); end
        n_vec++; if (a_out_ctrl !== 2'b00) begin n_err++; $display("FAIL flush1_ctrl got %b exp 00", a_out_ctrl); end
    endtask

    task automatic test_noskid();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_ctrl   = 2'b10;
        b_in_data   = 64'h11;
        step();
        n_vec++; if (b_out_data !== 64'h11) begin n_err++; $display("FAIL ns_first got %h exp 11", b_out_data); end
        b_in_data = 64'h22;
        #1;
        n_vec++; if (b_in_ready !== 1'b0) begin n_err++; $display("FAIL ns_rdy_stall got %b exp 0", b_in_ready); end
        step();
        n_vec++; if (b_out_data !== 64'h11) begin n_err++; $display("FAIL ns_hold got %h exp 11", b_out_data); end
        n_vec++; if (b_out_ctrl !== 2'b10) begin n_err++; $display("FAIL ns_hold_ctrl got %b exp 10", b_out_ctrl); end
        b_out_ready = 1'b1;
        #1;
        n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_rdy_pass got %b exp 1", b_in_ready); end
        step();
        b_in_valid = 1'b0;
        n_vec++; if (b_out_data !== 64'h22) begin n_err++; $display("FAIL ns_new got %h exp 22", b_out_data); end
        n_vec++; if (b_count !== 2'd1) begin n_err++; $display("FAIL ns_count got %0d exp 1", b_count); end
        step();
        n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL ns_empty got %b exp 0", b_out_valid); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_allones();
        pl_t exp [2];
        exp[0] = {2'b11, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        exp[1] = {2'b11, 32'h5A5A_A5A5, 64'hA5A5_5A5A_0F0F_F0F0};
        a_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1;
            {a_in_ctrl, a_in_instr, a_in_data} = exp[i];
            step();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({a_out_ctrl, a_out_instr, a_out_data} !== exp[i]) begin
                n_err++; $display("FAIL ones_%0d got %h exp %h", i, {a_out_ctrl, a_out_instr, a_out_data}, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_ctrl   = 2'b11;
        a_in_data   = 64'h1234;
        step();
        step();
        a_in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++; if (a_count !== 2'd0) begin n_err++; $display("FAIL mrst_count got %0d exp 0", a_count); end
        n_vec++; if (a_out_data !== 64'd0) begin n_err++; $display("FAIL mrst_data got %h exp 0", a_out_data); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_rdy got %b exp 1", a_in_ready); end
    endtask

    task automatic test_random();
        pl_t e;
        qa.delete();
        qb.delete();
        for (int c = 0; c < 10000; c++) begin
            n_vec++; if (int'(a_count) !== qa.size()) begin n_err++; $display("FAIL rnd_a_count c%0d got %0d exp %0d", c, a_count, qa.size()); end
            n_vec++; if (a_in_ready !== (qa.size() != 2)) begin n_err++; $display("FAIL rnd_a_rdy c%0d got %b exp %b", c, a_in_ready, qa.size() != 2); end
            n_vec++; if (int'(b_count) !== qb.size()) begin n_err++; $display("FAIL rnd_b_count c%0d got %0d exp %0d", c, b_count, qb.size()); end
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 99) == 0);
            a_in_data   = {$urandom, $urandom};
            a_in_instr  = $urandom;
            a_in_ctrl   = 2'($urandom_range(0, 3));
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 99) == 0);
            b_in_data   = {$urandom, $urandom};
            b_in_instr  = $urandom;
            b_in_ctrl   = 2'($urandom_range(0, 3));
            #1;
            if (!a_out_valid) begin
                n_vec++; if (a_out_ctrl !== 2'b00) begin n_err++; $display("FAIL rnd_a_bubble c%0d got %b exp 00", c, a_out_ctrl); end
            end
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_out_valid && a_out_ready) begin
                    e = (qa.size() > 0) ? qa.pop_front() : 'x;
                    n_vec++; if ({a_out_ctrl, a_out_instr, a_out_data} !== e) begin n_err++; $display("FAIL rnd_a_data c%0d got %h exp %h", c, {a_out_ctrl, a_out_instr, a_out_data}, e); end
                end
                if (a_in_valid && a_in_ready) qa.push_back({a_in_ctrl, a_in_instr, a_in_data});
            end
            if (!b_out_valid) begin
                n_vec++; if (b_out_ctrl !== 2'b00) begin n_err++; $display("FAIL rnd_b_bubble c%0d got %b exp 00", c, b_out_ctrl); end
            end
            n_vec++; if (b_in_ready !== (b_out_ready | (qb.size() == 0))) begin n_err++; $display("FAIL rnd_b_rdy c%0d got %b", c, b_in_ready); end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_out_valid && b_out_ready) begin
                    e = (qb.size() > 0) ? qb.pop_front() : 'x;
                    n_vec++; if ({b_out_ctrl, b_out_instr, b_out_data} !== e) begin n_err++; $display("FAIL rnd_b_data c%0d got %h exp %h", c, {b_out_ctrl, b_out_instr, b_out_data}, e); end
                end
                if (b_in_valid && b_in_ready) qb.push_back({b_in_ctrl, b_in_instr, b_in_data});
            end
            step();
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_flush    = 1'b0;
        b_flush    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_data = '0; a_in_instr = '0; a_in_ctrl = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_data = '0; b_in_instr = '0; b_in_ctrl = '0;
        test_reset();
        test_back_to_back();
        test_skid();
        test_flush();
        test_noskid();
        test_allones();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
